// File: rtl/led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// led_pattern_sequencer
//   Drives an 8-LED bank with one of four run-time selectable patterns
//   (FILL, RUN, PINGPONG, BLINK), stepped once every DIV clocks.
//
// Ports
//   clk        system clock, all state on posedge
//   rst        asynchronous active-high reset
//   mode[1:0]  pattern select, sampled only on mode_load
//   mode_load  single-cycle strobe: latch mode and restart the pattern
//   pause      level; while high the prescaler and pattern are frozen
//   led[7:0]   registered LED drive, bit 0 = rightmost LED
//   cycle_done one-clk pulse as led returns to the period's start value
// ---------------------------------------------------------------------------
module led_pattern_sequencer #(
  parameter int DIV   = 25000000,
  parameter int CNT_W = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  input  logic       mode_load,
  input  logic       pause,
  output logic [7:0] led,
  output logic       cycle_done
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_PAUSE = 2'd1,
    S_LOAD  = 2'd2
  } state_t;

  localparam logic [1:0] M_FILL     = 2'd0;
  localparam logic [1:0] M_RUN      = 2'd1;
  localparam logic [1:0] M_PINGPONG = 2'd2;
  localparam logic [1:0] M_BLINK    = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  // dir: 0 = moving toward bit 7 (left), 1 = moving toward bit 0 (right)
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  state_t           state;
  state_t           nxt_state;
  logic [1:0]       cur_mode;
  logic             dir;
  logic [CNT_W-1:0] cnt;

  logic             tick;
  logic             run_en;
  logic [7:0]       step_led;
  logic             step_dir;
  logic             step_wrap;

  // Start value of each pattern after reset or a load.
  function automatic logic [7:0] start_val(input logic [1:0] m);
    case (m)
      M_RUN,
      M_PINGPONG: start_val = 8'h01;
      default:    start_val = 8'h00;
    endcase
  endfunction

  assign tick = (cnt == CNT_LAST);

  // Next FSM state. mode_load overrides everything; a LOAD cycle behaves
  // like RUN (the prescaler counts from 0) unless pause is already high.
  always_comb begin
    nxt_state = state;
    case (state)
      S_RUN:   if (pause)  nxt_state = S_PAUSE;
      S_PAUSE: if (!pause) nxt_state = S_RUN;
      S_LOAD:  nxt_state = pause ? S_PAUSE : S_RUN;
      default: nxt_state = S_RUN;
    endcase
    if (mode_load) nxt_state = S_LOAD;
  end

  // The prescaler and pattern only move on edges that land in RUN.
  assign run_en = (nxt_state == S_RUN);

  // One pattern step from the current led/dir, plus the period-wrap flag.
  always_comb begin
    step_led  = led;
    step_dir  = dir;
    step_wrap = 1'b0;
    case (cur_mode)
      M_FILL: begin
        if (led == 8'hFF) begin
          step_led  = 8'h00;
          step_wrap = 1'b1;
        end else begin
          step_led = {led[6:0], 1'b1};
        end
      end
      M_RUN: begin
        step_led  = {led[6:0], led[7]};
        step_wrap = (led == 8'h80);
      end
      M_PINGPONG: begin
        // Direction flips on arrival at an end so neither end LED repeats.
        if (dir == DIR_LEFT) begin
          step_led = {led[6:0], 1'b0};
          if (led == 8'h40) step_dir = DIR_RIGHT;
        end else begin
          step_led = {1'b0, led[7:1]};
          if (led == 8'h02) begin
            step_dir  = DIR_LEFT;
            step_wrap = 1'b1;
          end
        end
      end
      M_BLINK: begin
        step_led  = (led == 8'h00) ? 8'hFF : 8'h00;
        step_wrap = (led == 8'hFF);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RUN;
      cur_mode   <= M_FILL;
      led        <= 8'h00;
      dir        <= DIR_LEFT;
      cnt        <= '0;
      cycle_done <= 1'b0;
    end else begin
      state      <= nxt_state;
      cycle_done <= 1'b0;
      if (mode_load) begin
        // Restart even if the mode is unchanged; a coincident tick is dropped.
        cur_mode <= mode;
        led      <= start_val(mode);
        dir      <= DIR_LEFT;
        cnt      <= '0;
      end else if (run_en) begin
        if (tick) begin
          cnt        <= '0;
          led        <= step_led;
          dir        <= step_dir;
          cycle_done <= step_wrap;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_sequencer
//   Two instances (DIV=4 and DIV=1) share the same stimulus. A reference
//   model tracks each instance as (mode, position in the pattern's sequence
//   table, prescaler count) and predicts led/cycle_done every clock.
// ---------------------------------------------------------------------------
module tb_led_pattern_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       mode_load;
  logic       pause;
  logic [7:0] led4, led1;
  logic       done4, done1;

  int n_assert = 0;
  int n_fail   = 0;

  led_pattern_sequencer #(.DIV(4), .CNT_W(2)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode), .mode_load(mode_load),
    .pause(pause), .led(led4), .cycle_done(done4)
  );

  led_pattern_sequencer #(.DIV(1), .CNT_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .mode(mode), .mode_load(mode_load),
    .pause(pause), .led(led1), .cycle_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int div_m [2] = '{4, 1};
  int md    [2];
  int idx   [2];
  int cnt   [2];
  bit done  [2];

  function automatic int seq_len(input int m);
    case (m)
      0: return 9;
      1: return 8;
      2: return 14;
      default: return 2;
    endcase
  endfunction

  function automatic logic [7:0] seq_val(input int m, input int i);
    case (m)
      0: return 8'((1 << i) - 1);
      1: return 8'(1 << i);
      2: return (i <= 7) ? 8'(1 << i) : 8'(1 << (14 - i));
      default: return (i != 0) ? 8'hFF : 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      md[i] = 0; idx[i] = 0; cnt[i] = 0; done[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      done[i] = 0;
      if (rst) begin
        md[i] = 0; idx[i] = 0; cnt[i] = 0;
      end else if (mode_load) begin
        md[i] = int'(mode); idx[i] = 0; cnt[i] = 0;
      end else if (!pause) begin
        if (cnt[i] == div_m[i] - 1) begin
          cnt[i]  = 0;
          idx[i]  = (idx[i] + 1) % seq_len(md[i]);
          done[i] = (idx[i] == 0);
        end else begin
          cnt[i]++;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk8("led_div4",  led4,  seq_val(md[0], idx[0]));
    chk1("done_div4", done4, done[0]);
    chk8("led_div1",  led1,  seq_val(md[1], idx[1]));
    chk1("done_div1", done1, done[1]);
  endtask

  // One clock: advance model on the edge, compare 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic load(input logic [1:0] m);
    mode = m; mode_load = 1'b1;
    cyc();
    mode_load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] held;
  bit         ok;

  initial begin
    rst = 1'b1; mode = 2'd0; mode_load = 1'b0; pause = 1'b0;
    model_reset();
    #1;
    check_model();
    run(3);
    rst = 1'b0;

    // FILL from reset, one full period plus margin
    run(40);

    // RUN: load and go past the 80->01 wrap
    load(2'd1);
    chk8("run_start", led4, 8'h01);
    run(40);

    // PINGPONG
    load(2'd2);
    run(40);

    // BLINK with a pause mid-count at prescaler=2
    load(2'd3);
    run(6);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      if (cnt[0] == 2) begin ok = 1; break; end
      cyc();
    end
    chk1("wait_cnt2", ok, 1'b1);
    held = led4;
    pause = 1'b1;
    run(10);
    chk8("pause_hold", led4, held);
    pause = 1'b0;
    cyc();
    chk8("resume_1clk", led4, held);
    cyc();
    chk8("resume_toggle", led4, ~held);
    run(10);

    // mode_load coincident with a tick while FILL sits at 3F
    load(2'd0);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (idx[0] == 6 && cnt[0] == 3) begin ok = 1; break; end
      cyc();
    end
    chk1("wait_fill_3f_tick", ok, 1'b1);
    chk8("fill_at_3f", led4, 8'h3F);
    load(2'd1);
    chk8("load_at_tick_led", led4, 8'h01);
    chk1("load_at_tick_done", done4, 1'b0);
    run(3);
    chk8("after_load_hold", led4, 8'h01);
    cyc();
    chk8("after_load_step", led4, 8'h02);
    run(5);

    // Async reset mid-cycle in PINGPONG at 20 moving right
    load(2'd2);
    ok = 0;
    for (int k = 0; k < 100; k++) begin
      if (idx[0] == 9) begin ok = 1; break; end
      cyc();
    end
    chk1("wait_pp_20_right", ok, 1'b1);
    chk8("pp_at_20", led4, 8'h20);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk8("async_rst_led4", led4, 8'h00);
    chk8("async_rst_led1", led1, 8'h00);
    chk1("async_rst_done4", done4, 1'b0);
    run(2);
    rst = 1'b0;
    run(40);

    // Randomized traffic: loads, pause toggling, occasional reset
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        mode      = 2'($urandom_range(0, 3));
        mode_load = 1'b1;
      end else begin
        mode_load = 1'b0;
      end
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      rst = ($urandom_range(0, 499) == 0);
      cyc();
    end
    rst = 1'b0; mode_load = 1'b0; pause = 1'b0;
    run(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
